// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional same-cycle
// write-to-read bypass and a per-register pending-write scoreboard for the issue stage.
module riscv_regfile_mp #(
    parameter int  XLEN   = 32,
    parameter int  NREG   = 32,
    parameter int  NUM_RD = 2,
    parameter int  NUM_WR = 1,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        i_re,
    input  logic [NUM_RD*AW-1:0]     i_raddr,
    output logic [NUM_RD*XLEN-1:0]   o_rdata,
    output logic [NUM_RD-1:0]        o_busy,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*AW-1:0]     i_waddr,
    input  logic [NUM_WR*XLEN-1:0]   i_wdata,
    input  logic                     i_alloc,
    input  logic [AW-1:0]            i_alloc_addr
);

    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic [NREG-1:0]           r_pend;

    logic [AW-1:0]   w_waddr  [NUM_WR];
    logic            w_wvalid [NUM_WR];
    logic [AW-1:0]   w_raddr  [NUM_RD];
    logic            w_hit    [NUM_RD];
    logic [XLEN-1:0] w_byp    [NUM_RD];
    logic            w_allocValid;

    // Addresses beyond NREG only exist when NREG is not a power of two.
    function automatic logic inRange(input logic [AW-1:0] a);
        return int'(a) < NREG;
    endfunction

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            w_waddr[w]  = i_waddr[w*AW +: AW];
            w_wvalid[w] = (w_waddr[w] != '0) && inRange(w_waddr[w]);
        end
        w_allocValid = i_alloc && (i_alloc_addr != '0) && inRange(i_alloc_addr);
    end

    // Later ports overwrite earlier ones, so the highest write port wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_we[w] && w_wvalid[w]) begin
                    r_regs[w_waddr[w]] <= i_wdata[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Allocation is applied after the write clears so a new producer supersedes the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_we[w] && w_wvalid[w]) begin
                    r_pend[w_waddr[w]] <= 1'b0;
                end
            end
            if (w_allocValid) begin
                r_pend[i_alloc_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        o_busy  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_raddr[p] = i_raddr[p*AW +: AW];
            w_hit[p]   = 1'b0;
            w_byp[p]   = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (BYPASS && i_we[w] && (w_waddr[w] == w_raddr[p])) begin
                    w_hit[p] = 1'b1;
                    w_byp[p] = i_wdata[w*XLEN +: XLEN];
                end
            end
            // Outputs are forced to zero while reset is held, even with a bypassing write present.
            if (rst_n && i_re[p] && (w_raddr[p] != '0) && inRange(w_raddr[p])) begin
                o_rdata[p*XLEN +: XLEN] = w_hit[p] ? w_byp[p] : r_regs[w_raddr[p]];
                o_busy[p]               = r_pend[w_raddr[p]] & ~w_hit[p];
            end
        end
    end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Self-checking bench: one bypassing dual-write instance and one non-bypassing
// single-write instance with a non-power-of-two register count.
module tb_riscv_regfile_mp;

    typedef struct {
        string       name;
        bit          dut;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        alloc;
        logic [4:0]  aa;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
    } vec_t;

    typedef struct {
        string       name;
        bit          dut;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [1:0]  aRe;
    logic [9:0]  aRaddr;
    logic [63:0] aRdata;
    logic [1:0]  aBusy;
    logic [1:0]  aWe;
    logic [9:0]  aWaddr;
    logic [63:0] aWdata;
    logic        aAlloc;
    logic [4:0]  aAllocAddr;

    logic [1:0]  bRe;
    logic [9:0]  bRaddr;
    logic [63:0] bRdata;
    logic [1:0]  bBusy;
    logic [0:0]  bWe;
    logic [4:0]  bWaddr;
    logic [31:0] bWdata;
    logic        bAlloc;
    logic [4:0]  bAllocAddr;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t expQ[$];
    vec_t vecA[18];
    vec_t vecB[10];

    riscv_regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) dutA (
        .clk(clk), .rst_n(rst_n),
        .i_re(aRe), .i_raddr(aRaddr), .o_rdata(aRdata), .o_busy(aBusy),
        .i_we(aWe), .i_waddr(aWaddr), .i_wdata(aWdata),
        .i_alloc(aAlloc), .i_alloc_addr(aAllocAddr)
    );

    riscv_regfile_mp #(.XLEN(32), .NREG(24), .NUM_RD(2), .NUM_WR(1), .BYPASS(1'b0)) dutB (
        .clk(clk), .rst_n(rst_n),
        .i_re(bRe), .i_raddr(bRaddr), .o_rdata(bRdata), .o_busy(bBusy),
        .i_we(bWe), .i_waddr(bWaddr), .i_wdata(bWdata),
        .i_alloc(bAlloc), .i_alloc_addr(bAllocAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, bit d, logic [1:0] re, logic [4:0] ra0, logic [4:0] ra1,
                                logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic alloc, logic [4:0] aa,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.name = n; v.dut = d; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.alloc = alloc; v.aa = aa; v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    task automatic driveVec(input vec_t v);
        aRe = '0; aRaddr = '0; aWe = '0; aWaddr = '0; aWdata = '0; aAlloc = 1'b0; aAllocAddr = '0;
        bRe = '0; bRaddr = '0; bWe = '0; bWaddr = '0; bWdata = '0; bAlloc = 1'b0; bAllocAddr = '0;
        if (!v.dut) begin
            aRe = v.re; aRaddr = {v.ra1, v.ra0}; aWe = v.we; aWaddr = {v.wa1, v.wa0};
            aWdata = {v.wd1, v.wd0}; aAlloc = v.alloc; aAllocAddr = v.aa;
        end else begin
            bRe = v.re; bRaddr = {v.ra1, v.ra0}; bWe = v.we[0]; bWaddr = v.wa0;
            bWdata = v.wd0; bAlloc = v.alloc; bAllocAddr = v.aa;
        end
    endtask

    task automatic pushExp(input vec_t v);
        exp_t e;
        e.name = v.name; e.dut = v.dut; e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveVec(v);
        pushExp(v);
    endtask

    task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        #2;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
            return;
        end
        e = expQ.pop_front();
        if (!e.dut) begin
            cmp({e.name, "/rdata0"}, aRdata[31:0],  e.e0);
            cmp({e.name, "/rdata1"}, aRdata[63:32], e.e1);
            cmp({e.name, "/busy"},   {30'b0, aBusy}, {30'b0, e.eb});
        end else begin
            cmp({e.name, "/rdata0"}, bRdata[31:0],  e.e0);
            cmp({e.name, "/rdata1"}, bRdata[63:32], e.e1);
            cmp({e.name, "/busy"},   {30'b0, bBusy}, {30'b0, e.eb});
        end
    endtask

    initial begin
        vec_t v;

        //                name             dut re     ra0 ra1 we     wa0 wd0           wa1 wd1     al aa  e0            e1            eb
        vecA[0]  = mk("A reset state",    0, 2'b11, 5,  0,  2'b00, 0,  0,            0,  0,      0, 0,  0,            0,            2'b00);
        vecA[1]  = mk("A wr x5 bypass",   0, 2'b01, 5,  0,  2'b01, 5,  32'hDEADBEEF, 0,  0,      0, 0,  32'hDEADBEEF, 0,            2'b00);
        vecA[2]  = mk("A rd x5",          0, 2'b11, 5,  5,  2'b00, 0,  0,            0,  0,      0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        vecA[3]  = mk("A wr x0",          0, 2'b11, 0,  5,  2'b01, 0,  32'hFFFFFFFF, 0,  0,      0, 0,  0,            32'hDEADBEEF, 2'b00);
        vecA[4]  = mk("A alloc x0",       0, 2'b01, 0,  0,  2'b00, 0,  0,            0,  0,      1, 0,  0,            0,            2'b00);
        vecA[5]  = mk("A x0 stays zero",  0, 2'b11, 0,  0,  2'b00, 0,  0,            0,  0,      0, 0,  0,            0,            2'b00);
        vecA[6]  = mk("A bypass x7",      0, 2'b11, 7,  7,  2'b01, 7,  32'h1234,     0,  0,      0, 0,  32'h1234,     32'h1234,     2'b00);
        vecA[7]  = mk("A collide x3",     0, 2'b11, 3,  7,  2'b11, 3,  32'hA,        3,  32'hB,  0, 0,  32'hB,        32'h1234,     2'b00);
        vecA[8]  = mk("A x3 stored",      0, 2'b11, 3,  0,  2'b00, 0,  0,            0,  0,      0, 0,  32'hB,        0,            2'b00);
        vecA[9]  = mk("A alloc x9",       0, 2'b01, 9,  0,  2'b00, 0,  0,            0,  0,      1, 9,  0,            0,            2'b00);
        vecA[10] = mk("A busy x9",        0, 2'b11, 9,  9,  2'b00, 0,  0,            0,  0,      0, 0,  0,            0,            2'b11);
        vecA[11] = mk("A wr+alloc x9",    0, 2'b11, 9,  3,  2'b01, 9,  32'h55,       0,  0,      1, 9,  32'h55,       32'hB,        2'b00);
        vecA[12] = mk("A x9 still busy",  0, 2'b11, 9,  9,  2'b00, 0,  0,            0,  0,      0, 0,  32'h55,       32'h55,       2'b11);
        vecA[13] = mk("A re gating",      0, 2'b10, 9,  3,  2'b00, 0,  0,            0,  0,      0, 0,  0,            32'hB,        2'b00);
        vecA[14] = mk("A wr x9 no alloc", 0, 2'b10, 9,  9,  2'b10, 0,  0,            9,  32'h66, 0, 0,  0,            32'h66,       2'b00);
        vecA[15] = mk("A x9 cleared",     0, 2'b11, 9,  5,  2'b00, 0,  0,            0,  0,      0, 0,  32'h66,       32'hDEADBEEF, 2'b00);
        vecA[16] = mk("A dual wr x4 x6",  0, 2'b00, 0,  0,  2'b11, 4,  32'hC4,       6,  32'hC6, 0, 0,  0,            0,            2'b00);
        vecA[17] = mk("A rd x4 x6",       0, 2'b11, 4,  6,  2'b00, 0,  0,            0,  0,      0, 0,  32'hC4,       32'hC6,       2'b00);

        vecB[0]  = mk("B wr x7",          1, 2'b00, 0,  0,  2'b01, 7,  32'h1111,     0,  0,      0, 0,  0,            0,            2'b00);
        vecB[1]  = mk("B no bypass",      1, 2'b11, 7,  7,  2'b01, 7,  32'h1234,     0,  0,      0, 0,  32'h1111,     32'h1111,     2'b00);
        vecB[2]  = mk("B x7 next cycle",  1, 2'b11, 7,  0,  2'b00, 0,  0,            0,  0,      0, 0,  32'h1234,     0,            2'b00);
        vecB[3]  = mk("B wr+alloc x25",   1, 2'b11, 25, 7,  2'b01, 25, 32'hBAD,      0,  0,      1, 25, 0,            32'h1234,     2'b00);
        vecB[4]  = mk("B rd x25 x24",     1, 2'b11, 25, 24, 2'b00, 0,  0,            0,  0,      0, 0,  0,            0,            2'b00);
        vecB[5]  = mk("B alloc x7",       1, 2'b01, 7,  0,  2'b00, 0,  0,            0,  0,      1, 7,  32'h1234,     0,            2'b00);
        vecB[6]  = mk("B busy unmasked",  1, 2'b11, 7,  7,  2'b01, 7,  32'h99,       0,  0,      0, 0,  32'h1234,     32'h1234,     2'b11);
        vecB[7]  = mk("B x7 cleared",     1, 2'b11, 7,  7,  2'b00, 0,  0,            0,  0,      0, 0,  32'h99,       32'h99,       2'b00);
        vecB[8]  = mk("B wr x23",         1, 2'b01, 23, 0,  2'b01, 23, 32'hABCD,     0,  0,      0, 0,  0,            0,            2'b00);
        vecB[9]  = mk("B rd x23 x24",     1, 2'b11, 23, 24, 2'b00, 0,  0,            0,  0,      0, 0,  32'hABCD,     0,            2'b00);

        rst_n = 1'b0;
        driveVec(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecA[i]) begin
            applyStimulus(vecA[i]);
            checkOutput();
        end
        foreach (vecB[i]) begin
            applyStimulus(vecB[i]);
            checkOutput();
        end

        // Mid-run reset with a bypassing write, a pending register and an allocation in flight.
        applyStimulus(mk("R alloc x12", 0, 2'b01, 12, 0, 2'b00, 0, 0, 0, 0, 1, 12, 0, 0, 2'b00));
        checkOutput();

        @(negedge clk);
        rst_n = 1'b0;
        v = mk("R during reset", 0, 2'b11, 5, 12, 2'b01, 5, 32'h1, 0, 0, 1, 12, 0, 0, 2'b00);
        driveVec(v);
        pushExp(v);
        checkOutput();

        @(negedge clk);
        rst_n = 1'b1;
        v = mk("R after release", 0, 2'b11, 5, 12, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        driveVec(v);
        pushExp(v);
        checkOutput();

        applyStimulus(mk("R x12 not pend", 0, 2'b11, 12, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        checkOutput();
        applyStimulus(mk("R B x7 cleared", 1, 2'b01, 7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
